trigger_input_conditioner: RTL and testbench
============================================

// Module: trigger_input_conditioner
// PURPOSE
//   Upstream stage of the normal-trigger rear edge detector: turns the asynchronous external trigger pin into a clean, glitch-free level.
//   2-FF synchronizer, programmable glitch filter (stable-level qualification), programmable holdoff after each accepted transition.
//   Trig_Clean drives the edge detector's Trig_Ain; Rise_Pulse/Fall_Pulse are available to other trigger logic.
// PARAMETERS
//   FW   8   width of Filt_Len and of the qualification counter
//   HW   16  width of Holdoff_Len and of the holdoff counter
// PORTS
//   Clock        in   1   single system clock, all logic on posedge
//   Reset_n      in   1   asynchronous, active-low reset
//   Trig_Raw     in   1   asynchronous external trigger pin
//   Cond_EN      in   1   enable; low = synchronous clear to reset state
//   Filt_Len     in   FW  extra stable cycles required (quasi-static)
//   Holdoff_Len  in   HW  cycles new transitions are ignored after acceptance
//   Trig_Clean   out  1   filtered trigger level
//   Rise_Pulse   out  1   1-cycle pulse, same edge Trig_Clean goes 0->1
//   Fall_Pulse   out  1   1-cycle pulse, same edge Trig_Clean goes 1->0
//   Holdoff_Busy out  1   high while holdoff counter is non-zero
//   Glitch_Cnt   out  16  rejected-glitch count (only with TRIG_COND_GLITCH_CNT_EN)
// BEHAVIOUR
// - Reset (Reset_n=0, async) or Cond_EN=0 (sync): sync FFs=0, state LOW, counters=0, all outputs 0.
// - s = Trig_Raw after two flops. FSM states: LOW, QUAL_H, HIGH, QUAL_L.
// - LOW: s=1 and Holdoff_Busy=0 -> QUAL_H, qcnt<=0. HIGH: s=0 and Holdoff_Busy=0 -> QUAL_L, qcnt<=0.
// - QUAL_H: s=0 -> LOW (glitch rejected); else qcnt>=Filt_Len -> HIGH, Trig_Clean<=1, Rise_Pulse<=1, hcnt<=Holdoff_Len; else qcnt++.
// - QUAL_L: mirror (s=1 -> HIGH rejected; accept -> LOW, Trig_Clean<=0, Fall_Pulse<=1, load hcnt).
// - Latency: Trig_Raw settled before edge 0 -> Trig_Clean/pulse registered at edge Filt_Len+3.
// - Minimum accepted width: s at new level on Filt_Len+2 consecutive edges; shorter pulses never reach Trig_Clean.
// - Compare is >= so a Filt_Len lowered mid-qualification accepts at next edge; qcnt never wraps.
// - Holdoff: hcnt decrements to 0 each cycle; Holdoff_Busy = (hcnt!=0). Holdoff_Len=0 -> no holdoff.
//   Level changes during holdoff are not lost: qualification starts the cycle after hcnt reaches 0 if s still differs.
// - Pulses are exactly one cycle; Rise and Fall never assert together.
// - Cond_EN falling mid-qualification/holdoff: next edge clears everything; no pulse emitted.
// CONFIGURATION
//   TRIG_COND_GLITCH_CNT_EN defined: Glitch_Cnt increments on every QUAL_H->LOW or QUAL_L->HIGH rejection,
//     saturates at 16'hFFFF, cleared by reset or Cond_EN=0.
//   Not defined: port Glitch_Cnt and its counter are absent; all other behaviour identical.
// STRUCTURE
//   trig_cond_pkg: state enum {LOW,QUAL_H,HIGH,QUAL_L} (2-bit), default FW/HW, GLITCH_CNT_W=16, GLITCH_CNT_MAX.
//   Sub-module trig_sync2: 2-FF synchronizer with async active-low reset, instantiated once for Trig_Raw.
//   FSM, qualification counter, holdoff counter and optional glitch counter live in the top module.
// TESTING
//   1 Filt_Len=0, Holdoff_Len=0, Trig_Raw 0->1 before edge 0 -> Trig_Clean=1 and Rise_Pulse 1 cycle at edge 3.
//   2 Filt_Len=4, 5-cycle high pulse on Trig_Raw -> Trig_Clean stays 0; 6-cycle pulse -> Rise at edge 7, Fall follows; glitch count 1 (macro on).
//   3 Filt_Len=0, Holdoff_Len=10, rise then fall 3 cycles later -> Holdoff_Busy 10 cycles, Fall_Pulse not before holdoff ends.
//   4 Glitch storm 70000 rejected pulses, macro on -> Glitch_Cnt saturates at 16'hFFFF, no pulses out.
//   5 Cond_EN=0 mid-QUAL_H and mid-holdoff -> all outputs 0 next edge; Reset_n low between edges -> outputs 0 immediately.
//   6 Filt_Len lowered 8->2 while qcnt=5 -> accept at next edge, exactly one Rise_Pulse.

Source files
------------

// File: rtl/trig_cond_pkg.sv
// Shared types and defaults for the trigger input conditioner.
// The state enum is exported so the bench and the debug port use one encoding.
package trig_cond_pkg;

  localparam int FW_DEF       = 8;
  localparam int HW_DEF       = 16;
  localparam int GLITCH_CNT_W = 16;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    QUAL_H = 2'd1,
    HIGH   = 2'd2,
    QUAL_L = 2'd3
  } state_t;

endpackage

// File: rtl/trigger_input_conditioner_if.sv
// Signal bundle between the trigger pin logic and the conditioner.
// Glitch_Cnt exists only when TRIG_COND_GLITCH_CNT_EN is defined.
interface trigger_input_conditioner_if
  import trig_cond_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int HW = HW_DEF
);
  // No valid/ready handshake: every input is a level sampled on each clock,
  // Filt_Len/Holdoff_Len are quasi-static, outputs are registered levels/pulses.
  logic          Trig_Raw;
  logic          Cond_EN;
  logic [FW-1:0] Filt_Len;
  logic [HW-1:0] Holdoff_Len;
  logic          Trig_Clean;
  logic          Rise_Pulse;
  logic          Fall_Pulse;
  logic          Holdoff_Busy;
  state_t        dbg_state;
`ifdef TRIG_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] Glitch_Cnt;

  modport master (
    output Trig_Raw, Cond_EN, Filt_Len, Holdoff_Len,
    input  Trig_Clean, Rise_Pulse, Fall_Pulse, Holdoff_Busy, dbg_state, Glitch_Cnt
  );
  modport slave (
    input  Trig_Raw, Cond_EN, Filt_Len, Holdoff_Len,
    output Trig_Clean, Rise_Pulse, Fall_Pulse, Holdoff_Busy, dbg_state, Glitch_Cnt
  );
`else
  modport master (
    output Trig_Raw, Cond_EN, Filt_Len, Holdoff_Len,
    input  Trig_Clean, Rise_Pulse, Fall_Pulse, Holdoff_Busy, dbg_state
  );
  modport slave (
    input  Trig_Raw, Cond_EN, Filt_Len, Holdoff_Len,
    output Trig_Clean, Rise_Pulse, Fall_Pulse, Holdoff_Busy, dbg_state
  );
`endif
endinterface

// File: rtl/trig_sync2.sv
// Two-flop synchronizer for the asynchronous trigger pin, with a synchronous
// clear so a disabled conditioner restarts from a known-low history.
module trig_sync2 (
  input  logic Clock,
  input  logic Reset_n,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [1:0] ff;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ff <= '0;
    end else if (clr) begin
      ff <= '0;
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];
endmodule

// File: rtl/trigger_input_conditioner.sv
// Synchronizes, glitch-filters and holds off the external trigger pin.
// Define TRIG_COND_GLITCH_CNT_EN to add the saturating rejected-glitch counter.
module trigger_input_conditioner
  import trig_cond_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic Clock,
  input  logic Reset_n,
  trigger_input_conditioner_if.slave bus
);
  logic          s;
  logic          en;
  state_t        state, state_nxt;
  logic [FW-1:0] qcnt;
  logic [HW-1:0] hcnt;
  logic          busy;
  logic          qual_done;
  logic          accept_rise, accept_fall, reject;
  logic          rise_q, fall_q;

  assign en = bus.Cond_EN;

  trig_sync2 u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clr     (!en),
    .d       (bus.Trig_Raw),
    .q       (s)
  );

  assign busy        = (hcnt != '0);
  // >= lets a Filt_Len lowered mid-qualification accept on the next edge.
  assign qual_done   = (qcnt >= bus.Filt_Len);
  assign accept_rise = (state == QUAL_H) &&  s && qual_done;
  assign accept_fall = (state == QUAL_L) && !s && qual_done;
  assign reject      = ((state == QUAL_H) && !s) || ((state == QUAL_L) && s);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= LOW;
    end else if (!en) begin
      state <= LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOW:     if (s && !busy) state_nxt = QUAL_H;
      QUAL_H:  if (!s) state_nxt = LOW;
               else if (qual_done) state_nxt = HIGH;
      HIGH:    if (!s && !busy) state_nxt = QUAL_L;
      QUAL_L:  if (s) state_nxt = HIGH;
               else if (qual_done) state_nxt = LOW;
      default: state_nxt = LOW;
    endcase
  end

  always_comb begin
    bus.Trig_Clean = (state == HIGH) || (state == QUAL_L);
    bus.dbg_state  = state;
  end

  // qcnt idles at 0 in the stable states, so entering qualification starts at 0.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      qcnt <= '0;
    end else if (!en || state == LOW || state == HIGH) begin
      qcnt <= '0;
    end else if (!qual_done) begin
      qcnt <= qcnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
    end else if (accept_rise || accept_fall) begin
      hcnt <= bus.Holdoff_Len;
    end else if (busy) begin
      hcnt <= hcnt - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= en && accept_rise;
      fall_q <= en && accept_fall;
    end
  end

  assign bus.Rise_Pulse   = rise_q;
  assign bus.Fall_Pulse   = fall_q;
  assign bus.Holdoff_Busy = busy;

`ifdef TRIG_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      glitch_cnt <= '0;
    end else if (!en) begin
      glitch_cnt <= '0;
    end else if (reject && glitch_cnt != GLITCH_CNT_MAX) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

  assign bus.Glitch_Cnt = glitch_cnt;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif
endmodule

// File: tb/tb_trigger_input_conditioner.sv
// Bench for trigger_input_conditioner: vector table plus hand-written corner sequences,
// pulse events checked against an expected-event queue.
`timescale 1ns/1ps
module tb_trigger_input_conditioner;
  import trig_cond_pkg::*;

  localparam int FW = 8;
  localparam int HW = 16;
  localparam int EW = 16;
`ifdef TRIG_COND_GLITCH_CNT_EN
  localparam int STORM_N = 70000;
`else
  localparam int STORM_N = 300;
`endif

  typedef struct {
    int filt;
    int hold;
    int width;
    int n_rise;
    int rise_at;
    int fall_at;
    int busy;
    int glitch;
  } vec_t;

  // clock / reset
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  trigger_input_conditioner_if #(.FW(FW), .HW(HW)) bus();
  trigger_input_conditioner #(.FW(FW), .HW(HW)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   base = 0;
  int   rise_total = 0;
  int   busy_total = 0;
  logic mon_on = 1'b1;
  vec_t vecs[9];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Relative edge n: edge 0 is the first posedge after base was captured.
  task automatic wait_to(input int n);
    while (cyc - base - 1 < n) @(negedge Clock);
  endtask

  task automatic monitor();
    logic prev_clean;
    logic [EW-1:0] obs, want;
    prev_clean = 1'b0;
    forever begin
      @(negedge Clock);
      if (bus.Rise_Pulse) rise_total++;
      if (bus.Holdoff_Busy) busy_total++;
      if (mon_on && (bus.Rise_Pulse || bus.Fall_Pulse || bus.Trig_Clean != prev_clean)) begin
        check("pulse_vs_level", int'({bus.Rise_Pulse, bus.Fall_Pulse}),
              int'({bus.Trig_Clean & ~prev_clean, ~bus.Trig_Clean & prev_clean}));
        if (bus.Rise_Pulse || bus.Fall_Pulse) begin
          obs = {bus.Fall_Pulse, 15'(cyc - base - 1)};
          check("pulse_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("pulse_event", int'(obs), int'(want));
          end
        end
      end
      prev_clean = bus.Trig_Clean;
    end
  endtask

  // driver tasks
  task automatic clear_dut(input int f, input int h);
    @(negedge Clock);
    bus.Cond_EN  = 1'b0;
    bus.Trig_Raw = 1'b0;
    @(negedge Clock);
    bus.Cond_EN     = 1'b1;
    bus.Filt_Len    = FW'(f);
    bus.Holdoff_Len = HW'(h);
    @(negedge Clock);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int r0, b0;
    clear_dut(v.filt, v.hold);
    r0 = rise_total;
    b0 = busy_total;
    base = cyc;
    if (v.n_rise != 0) begin
      exp_q.push_back({1'b0, 15'(v.rise_at)});
      exp_q.push_back({1'b1, 15'(v.fall_at)});
    end
    bus.Trig_Raw = 1'b1;
    wait_to(v.width - 1);
    bus.Trig_Raw = 1'b0;
    wait_to(v.width + 2 * v.hold + v.filt + 40);
    check({tag, "_rises"}, rise_total - r0, v.n_rise);
    check({tag, "_busy"}, busy_total - b0, v.busy);
    check({tag, "_q_empty"}, exp_q.size(), 0);
`ifdef TRIG_COND_GLITCH_CNT_EN
    check({tag, "_glitch"}, int'(bus.Glitch_Cnt), v.glitch);
`endif
    exp_q.delete();
  endtask

  initial begin
    int r0;
    //          filt hold width rise rise_at fall_at busy glitch
    vecs[0] = '{0,   0,   2,    1,   3,      5,      0,   0};
    vecs[1] = '{0,   0,   1,    0,   0,      0,      0,   1};
    vecs[2] = '{4,   0,   5,    0,   0,      0,      0,   1};
    vecs[3] = '{4,   0,   6,    1,   7,      13,     0,   0};
    vecs[4] = '{0,   10,  3,    1,   3,      15,     20,  0};
    vecs[5] = '{2,   3,   10,   1,   5,      15,     6,   0};
    vecs[6] = '{3,   20,  5,    1,   6,      31,     40,  0};
    vecs[7] = '{7,   0,   8,    0,   0,      0,      0,   1};
    vecs[8] = '{1,   0,   3,    1,   4,      7,      0,   0};

    bus.Trig_Raw    = 1'b0;
    bus.Cond_EN     = 1'b0;
    bus.Filt_Len    = '0;
    bus.Holdoff_Len = '0;
    fork
      monitor();
    join_none

    // reset state
    bus.Trig_Raw = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_clean", int'(bus.Trig_Clean), 0);
    check("rst_rise", int'(bus.Rise_Pulse), 0);
    check("rst_fall", int'(bus.Fall_Pulse), 0);
    check("rst_busy", int'(bus.Holdoff_Busy), 0);
    check("rst_state", int'(bus.dbg_state), int'(LOW));
    bus.Trig_Raw = 1'b0;
    Reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Cond_EN dropped mid-qualification
    clear_dut(8, 0);
    base = cyc;
    r0 = rise_total;
    bus.Trig_Raw = 1'b1;
    wait_to(5);
    check("en_mid_qual_pre", int'(bus.dbg_state), int'(QUAL_H));
    bus.Cond_EN = 1'b0;
    @(negedge Clock);
    check("en_mid_qual_state", int'(bus.dbg_state), int'(LOW));
    check("en_mid_qual_clean", int'(bus.Trig_Clean), 0);
    bus.Trig_Raw = 1'b0;
    bus.Cond_EN = 1'b1;
    repeat (20) @(negedge Clock);
    check("en_mid_qual_rises", rise_total - r0, 0);

    // Cond_EN dropped mid-holdoff
    clear_dut(0, 50);
    base = cyc;
    exp_q.push_back({1'b0, 15'd3});
    bus.Trig_Raw = 1'b1;
    wait_to(10);
    check("en_mid_hold_busy_pre", int'(bus.Holdoff_Busy), 1);
    check("en_mid_hold_clean_pre", int'(bus.Trig_Clean), 1);
    mon_on = 1'b0;
    bus.Cond_EN = 1'b0;
    bus.Trig_Raw = 1'b0;
    @(negedge Clock);
    check("en_mid_hold_clean", int'(bus.Trig_Clean), 0);
    check("en_mid_hold_busy", int'(bus.Holdoff_Busy), 0);
    check("en_mid_hold_pulses", int'({bus.Rise_Pulse, bus.Fall_Pulse}), 0);
    check("en_mid_hold_state", int'(bus.dbg_state), int'(LOW));
    check("en_mid_hold_q", exp_q.size(), 0);
    bus.Cond_EN = 1'b1;
    @(negedge Clock);
    mon_on = 1'b1;

    // asynchronous reset between edges
    clear_dut(0, 0);
    base = cyc;
    exp_q.push_back({1'b0, 15'd3});
    bus.Trig_Raw = 1'b1;
    wait_to(6);
    check("async_rst_clean_pre", int'(bus.Trig_Clean), 1);
    mon_on = 1'b0;
    #2;
    Reset_n = 1'b0;
    bus.Trig_Raw = 1'b0;
    #1;
    check("async_rst_clean", int'(bus.Trig_Clean), 0);
    check("async_rst_state", int'(bus.dbg_state), int'(LOW));
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    mon_on = 1'b1;

    // Filt_Len lowered mid-qualification
    clear_dut(8, 0);
    base = cyc;
    r0 = rise_total;
    exp_q.push_back({1'b0, 15'd8});
    exp_q.push_back({1'b1, 15'd18});
    bus.Trig_Raw = 1'b1;
    wait_to(7);
    bus.Filt_Len = FW'(2);
    wait_to(12);
    bus.Trig_Raw = 1'b0;
    wait_to(30);
    check("filt_lower_rises", rise_total - r0, 1);
    check("filt_lower_q", exp_q.size(), 0);
    exp_q.delete();

    // glitch storm
    clear_dut(0, 0);
    r0 = rise_total;
    for (int i = 0; i < STORM_N; i++) begin
      bus.Trig_Raw = 1'b1;
      @(negedge Clock);
      bus.Trig_Raw = 1'b0;
      @(negedge Clock);
    end
    repeat (5) @(negedge Clock);
    check("storm_rises", rise_total - r0, 0);
    check("storm_clean", int'(bus.Trig_Clean), 0);
`ifdef TRIG_COND_GLITCH_CNT_EN
    check("storm_glitch", int'(bus.Glitch_Cnt), int'(GLITCH_CNT_MAX));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
